// File: rtl/time_tmr_rr_arbiter_if.sv
// Bus bundle for time_tmr_rr_arbiter: requester streams, the TMR issue/return pair and status.
// Carries grant_cnt_o only when TIME_TMR_ARB_STATS_EN is defined.
interface time_tmr_rr_arbiter_if #(
    parameter int NumReq         = 4,
    parameter int DataWidth      = 8,
    parameter int MaxOutstanding = 4
);
    localparam int TagWidth = $clog2(NumReq);
    localparam int CntWidth = $clog2(MaxOutstanding + 1);

    logic [NumReq-1:0][DataWidth-1:0] req_data_i;
    logic [NumReq-1:0]                req_valid_i;
    logic [NumReq-1:0]                req_ready_o;
    logic [TagWidth+DataWidth-1:0]    tmr_data_o;
    logic                             tmr_valid_o;
    logic                             tmr_ready_i;
    logic [TagWidth+DataWidth-1:0]    tmr_data_i;
    logic                             tmr_valid_i;
    logic                             tmr_ready_o;
    logic [DataWidth-1:0]             rsp_data_o;
    logic [NumReq-1:0]                rsp_valid_o;
    logic [NumReq-1:0]                rsp_ready_i;
    logic [CntWidth-1:0]              outstanding_o;
    logic                             tag_error_o;
`ifdef TIME_TMR_ARB_STATS_EN
    logic [NumReq-1:0][15:0]          grant_cnt_o;
`endif

    // The arbiter itself
    modport slave (
        input  req_data_i, req_valid_i, tmr_ready_i, tmr_data_i, tmr_valid_i, rsp_ready_i,
        output req_ready_o, tmr_data_o, tmr_valid_o, tmr_ready_o, rsp_data_o, rsp_valid_o,
`ifdef TIME_TMR_ARB_STATS_EN
        output grant_cnt_o,
`endif
        output outstanding_o, tag_error_o
    );

    // Requesters plus the TMR pair, seen from outside the arbiter
    modport master (
        output req_data_i, req_valid_i, tmr_ready_i, tmr_data_i, tmr_valid_i, rsp_ready_i,
        input  req_ready_o, tmr_data_o, tmr_valid_o, tmr_ready_o, rsp_data_o, rsp_valid_o,
`ifdef TIME_TMR_ARB_STATS_EN
        input  grant_cnt_o,
`endif
        input  outstanding_o, tag_error_o
    );
endinterface

// File: rtl/time_tmr_rr_arbiter.sv
// Round-robin front end sharing one time_TMR_start/time_TMR_end pair among NumReq requesters,
// with tag-routed returns and an in-flight credit limit. Optional per-requester grant
// counters are built when TIME_TMR_ARB_STATS_EN is defined.
module time_tmr_rr_arbiter #(
    parameter int NumReq         = 4,
    parameter int DataWidth      = 8,
    parameter int MaxOutstanding = 4
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    time_tmr_rr_arbiter_if.slave   bus
);
    localparam int TagWidth = $clog2(NumReq);
    localparam int CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MaxOutstanding);
    localparam logic [TagWidth-1:0] LastTag = TagWidth'(NumReq - 1);

    typedef enum logic {IDLE, LOCK} state_e;

    state_e              state_reg;
    logic [TagWidth-1:0] rr_ptr_reg;
    logic [TagWidth-1:0] grant_reg;
    logic [CntWidth-1:0] outstanding_reg;
    logic                tag_error_reg;

    logic [TagWidth-1:0] pick;
    logic                pick_found;
    logic [TagWidth-1:0] sel;
    logic                sel_valid;
    logic [TagWidth-1:0] next_ptr;
    logic [NumReq-1:0]   req_ready;
    logic                issue_hs;

    logic [TagWidth-1:0] rsp_tag;
    logic                tag_bad;
    logic [NumReq-1:0]   rsp_valid;
    logic                tmr_ready;
    logic                return_hs;

    // Scan offsets from the far end so the smallest offset from rr_ptr wins
    always_comb begin : arbitrate
        pick       = rr_ptr_reg;
        pick_found = 1'b0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (bus.req_valid_i[(int'(rr_ptr_reg) + k) % NumReq]) begin
                pick       = TagWidth'((int'(rr_ptr_reg) + k) % NumReq);
                pick_found = 1'b1;
            end
        end
        if (state_reg == LOCK) begin
            sel       = grant_reg;
            sel_valid = bus.req_valid_i[grant_reg];
        end else begin
            sel       = pick;
            sel_valid = pick_found && (outstanding_reg < MaxCnt);
        end
        req_ready = '0;
        if (sel_valid) begin
            req_ready[sel] = bus.tmr_ready_i;
        end
    end

    assign issue_hs        = sel_valid & bus.tmr_ready_i;
    assign next_ptr        = (sel == LastTag) ? '0 : sel + 1'b1;
    assign bus.tmr_valid_o = sel_valid;
    assign bus.tmr_data_o  = {sel, bus.req_data_i[sel]};
    assign bus.req_ready_o = req_ready;

    assign rsp_tag        = bus.tmr_data_i[TagWidth+DataWidth-1 -: TagWidth];
    assign bus.rsp_data_o = bus.tmr_data_i[DataWidth-1:0];

    // Out-of-range tags only exist when NumReq does not fill the tag space
    if ((1 << TagWidth) == NumReq) begin : g_dense_tags
        assign tag_bad = 1'b0;
    end else begin : g_sparse_tags
        assign tag_bad = int'(rsp_tag) >= NumReq;
    end

    always_comb begin : route_return
        rsp_valid = '0;
        tmr_ready = 1'b1;
        if (!tag_bad) begin
            rsp_valid[rsp_tag] = bus.tmr_valid_i;
            tmr_ready          = bus.rsp_ready_i[rsp_tag];
        end
    end

    assign return_hs         = bus.tmr_valid_i & tmr_ready;
    assign bus.rsp_valid_o   = rsp_valid;
    assign bus.tmr_ready_o   = tmr_ready;
    assign bus.outstanding_o = outstanding_reg;
    assign bus.tag_error_o   = tag_error_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin : issue_fsm
        if (!rst_ni) begin
            state_reg       <= IDLE;
            rr_ptr_reg      <= '0;
            grant_reg       <= '0;
            outstanding_reg <= '0;
            tag_error_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sel_valid) begin
                        if (bus.tmr_ready_i) begin
                            rr_ptr_reg <= next_ptr;
                        end else begin
                            grant_reg <= sel;
                            state_reg <= LOCK;
                        end
                    end
                end
                LOCK: begin
                    if (issue_hs) begin
                        rr_ptr_reg <= next_ptr;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // A dropped bad-tag beat still releases its credit
            case ({issue_hs, return_hs})
                2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
                2'b01:   if (outstanding_reg != '0) outstanding_reg <= outstanding_reg - 1'b1;
                default: outstanding_reg <= outstanding_reg;
            endcase

            tag_error_reg <= bus.tmr_valid_i & tag_bad;
        end
    end

`ifdef TIME_TMR_ARB_STATS_EN
    logic [15:0] grant_cnt_reg [NumReq];

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_stats
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                grant_cnt_reg[gi] <= '0;
            end else if (issue_hs && (sel == TagWidth'(gi)) && (grant_cnt_reg[gi] != 16'hFFFF)) begin
                grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 16'd1;
            end
        end
        assign bus.grant_cnt_o[gi] = grant_cnt_reg[gi];
    end
`endif

endmodule
